rf_scoreboard: RTL
==================

Name: rf_scoreboard

Overview:
- Parametrised successor to the 4x16 register file: 2^ADDR_W entries of DATA_W bits, NUM_RD asynchronous read ports and one synchronous write port.
- Adds a per-register busy scoreboard. Decode reserves a destination; writeback clears the reservation. This lets the control FSM stall on RAW hazards.
- Sits between decode (reads, reserve) and writeback (write) in the multi-cycle and pipelined CPU.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and the scoreboard
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = the register addressed by port i has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  reservation request from decode
- rsv_addr  in  ADDR_W  destination to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_vec  out  DEPTH  busy bit per register
- busy_cnt  out  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While reset = 1, all regs = 0, busy_vec = 0 and busy_cnt = 0. rd_data then reads 0 and rd_busy = 0. Reset mid-operation discards all reservations and pending writes; the first edge after deassertion operates normally.
- Reads: combinational, zero latency. rd_data[i] = regs[rd_addr[i]]; rd_busy[i] = busy_vec[rd_addr[i]]. Ports are fully independent. The same address on several ports is legal.
- Write: on posedge clk with wr_en = 1, regs[wr_addr] <= wr_data. The new value is visible to reads after the edge. Writing a non-busy register is legal and leaves busy unchanged.
- Reservation: rsv_ok = rsv_en & (~busy_vec[rsv_addr] | (wr_en & wr_addr == rsv_addr)). On the edge, if rsv_ok is set, busy[rsv_addr] <= 1. If rsv_en = 1 and the request is refused (rsv_ok = 0), state does not change; decode must hold the request and retry.
- Clear: on the edge, if wr_en = 1 and busy[wr_addr] = 1, busy[wr_addr] <= 0, unless the same register is reserved in the same cycle.
- Simultaneous clear and reserve on the same address: the reserve wins and busy stays 1. The write still updates the data. The register now awaits the newer producer.
- Simultaneous clear and reserve on different addresses: both take effect on the same edge.
- busy_cnt: updated on the edge by +1 (reserve only), -1 (clear only) or 0 (both, or neither). It always equals popcount(busy_vec). Its range is 0..DEPTH with no wrap, which is guaranteed by construction since a register cannot be reserved twice.
- Entries: no hardwired-zero register; all DEPTH entries are writable.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- Defined: when wr_en = 1 and wr_addr == rd_addr[i] in the same cycle, rd_data[i] = wr_data and rd_busy[i] = 0, unless that register is also being reserved this cycle, in which case rd_busy[i] = 1. This saves one stall cycle on writeback-to-decode.
- Undefined: reads return the pre-edge register value and the pre-edge busy bit; the consumer stalls one extra cycle.

Decomposition:
- Package rf_pkg holds the DATA_W and ADDR_W defaults and the function clog2_cnt used for the busy_cnt width.
- One natural sub-module, rf_read_port: an address mux plus optional bypass. It is instantiated NUM_RD times via generate. The storage array and scoreboard stay in the top module.

Test Plan:
- Reset check: reset = 1 asynchronously mid-cycle after regs were written → rd_data = 0, busy_vec = 0, busy_cnt = 0 immediately, without waiting for a clock edge.
- Basic write/read: write 0xBEEF to r2, then 0x1234 to r3; set rd_addr = {3,2} → rd_data = {0x1234, 0xBEEF}; rd_busy = 0.
- Reserve and stall: reserve r1 (rsv_ok = 1); next cycle rsv_addr = 1 again → rsv_ok = 0, busy_cnt stays 1. Read r1 → rd_busy = 1 until a wr_en to r1 occurs, then busy_cnt = 0.
- Same-cycle clear+reserve of r1: wr_en = 1, wr_addr = 1, wr_data = 0x00AA, rsv_en = 1, rsv_addr = 1 → rsv_ok = 1, after the edge busy[1] = 1, regs[1] = 0x00AA, busy_cnt unchanged.
- Fill all: reserve r0..r3 on successive cycles → busy_cnt = 4, busy_vec = 4'hF. Clear r2 while reserving nothing → busy_cnt = 3.
- Bypass: write 0x5555 to r0 while rd_addr[0] = 0 → with RF_WRITE_BYPASS_EN, rd_data[0] = 0x5555 in the same cycle; without it, the old value is returned and 0x5555 appears after the edge.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the register file with busy scoreboard.
// RF_WRITE_BYPASS_EN (optional macro) is consumed by rf_read_port; nothing here depends on it.
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 2;
    localparam int RF_NUM_RD = 2;

    // Bits needed to hold a count in the range 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
// Selects the addressed register and its busy bit. With RF_WRITE_BYPASS_EN
// defined, a same-cycle writeback to the addressed register is forwarded
// (data from wr_data, busy cleared unless the register is being re-reserved
// on this same edge). Without it the pre-edge value and busy bit are returned.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0]                addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0]    regs_flat,
    input  logic [(2**ADDR_W)-1:0]           busy_vec,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             rsv_ok,
    input  logic [ADDR_W-1:0]                rsv_addr,
    output logic [DATA_W-1:0]                data,
    output logic                             busy
);

    logic [DATA_W-1:0] stored_data;
    logic              stored_busy;

    assign stored_data = regs_flat[addr*DATA_W +: DATA_W];
    assign stored_busy = busy_vec[addr];

`ifdef RF_WRITE_BYPASS_EN
    logic wr_hit;
    assign wr_hit = wr_en && (wr_addr == addr);

    // Forward the in-flight writeback; a same-edge re-reservation keeps it busy.
    always_comb begin
        data = stored_data;
        busy = stored_busy;
        if (wr_hit) begin
            data = wr_data;
            busy = rsv_ok && (rsv_addr == addr);
        end
    end
`else
    assign data = stored_data;
    assign busy = stored_busy;

    // Writeback and reservation inputs only matter for forwarding.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data, rsv_ok, rsv_addr};
`endif

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: 2**ADDR_W x DATA_W register file with NUM_RD asynchronous
// read ports, one synchronous write port and a per-register busy scoreboard.
// Decode reserves a destination (rsv_en/rsv_ok); writeback (wr_en) clears it.
// Optional macro: RF_WRITE_BYPASS_EN enables write-to-read forwarding in the
// read ports.
//
// Reservation handshake: rsv_en is the request and rsv_ok the combinational
// grant in the same cycle; the reservation is recorded on the clock edge only
// when both are high. A refused request changes nothing and decode must keep
// rsv_en/rsv_addr stable until it is granted.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_ok,
    output logic [(2**ADDR_W)-1:0]     busy_vec,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = clog2_cnt(DEPTH);

    logic [DEPTH*DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]        busy_q;
    logic [CNT_W-1:0]        busy_cnt_q;

    logic same_addr;
    logic clr_take;
    logic cnt_inc;
    logic cnt_dec;

    // A busy register may be re-reserved only when its writeback lands this cycle.
    assign rsv_ok    = rsv_en && (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
    assign same_addr = rsv_ok && (rsv_addr == wr_addr);
    // Clear happens only if the register was busy and is not re-reserved now.
    assign clr_take  = wr_en && busy_q[wr_addr] && !same_addr;
    // Count moves only on real 0->1 / 1->0 transitions of the busy bits.
    assign cnt_inc   = rsv_ok && !busy_q[rsv_addr];
    assign cnt_dec   = clr_take;

    assign busy_vec = busy_q;
    assign busy_cnt = busy_cnt_q;

    // Register storage: synchronous write, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (wr_en) begin
            regs_q[wr_addr*DATA_W +: DATA_W] <= wr_data;
        end
    end

    // Busy scoreboard: clear first, then reserve, so a same-register reserve wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            if (clr_take) begin
                busy_q[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                busy_q[rsv_addr] <= 1'b1;
            end
        end
    end

    // Busy count tracks popcount(busy_q); bounded to 0..DEPTH by construction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_q <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            busy_cnt_q <= busy_cnt_q + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            busy_cnt_q <= busy_cnt_q - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .addr      (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs_flat (regs_q),
            .busy_vec  (busy_q),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rsv_ok    (rsv_ok),
            .rsv_addr  (rsv_addr),
            .data      (rd_data[i*DATA_W +: DATA_W]),
            .busy      (rd_busy[i])
        );
    end

endmodule
